// File: rtl/aes_pkg.sv
// Shared AES definitions for the AES-256 decryption key scheduler.
// Contents: round counts, RCON constants, word/round-key typedefs, scheduler
// FSM state enum, and GF(2^8) helpers for InvMixColumns. The InvMixColumns
// helpers are only instantiated when AES_EQ_INV_CIPHER_EN is defined.
package aes_pkg;

  localparam int unsigned AES256_NR     = 14;
  localparam int unsigned AES256_NUM_RK = AES256_NR + 1;
  localparam int unsigned AES_WORD_W    = 32;
  localparam int unsigned AES_RK_W      = 128;

  typedef logic [AES_WORD_W-1:0] aes_word_t;
  typedef logic [AES_RK_W-1:0]   aes_rk_t;

  // Round constants used by the AES-256 expansion, one per even round key
  localparam logic [7:0] AES_RCON [7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_EXPAND = 2'd1,
    KS_DONE   = 2'd2
  } key_sched_state_e;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] aes_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // InvMixColumns on one column; byte 0 of the column is the MSB
  function automatic aes_word_t aes_inv_mix_col(input aes_word_t c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {aes_gmul(a0, 8'h0e) ^ aes_gmul(a1, 8'h0b) ^ aes_gmul(a2, 8'h0d) ^ aes_gmul(a3, 8'h09),
            aes_gmul(a0, 8'h09) ^ aes_gmul(a1, 8'h0e) ^ aes_gmul(a2, 8'h0b) ^ aes_gmul(a3, 8'h0d),
            aes_gmul(a0, 8'h0d) ^ aes_gmul(a1, 8'h09) ^ aes_gmul(a2, 8'h0e) ^ aes_gmul(a3, 8'h0b),
            aes_gmul(a0, 8'h0b) ^ aes_gmul(a1, 8'h0d) ^ aes_gmul(a2, 8'h09) ^ aes_gmul(a3, 8'h0e)};
  endfunction

  // InvMixColumns applied to all four columns of a round key
  function automatic aes_rk_t aes_inv_mix_rk(input aes_rk_t rk);
    return {aes_inv_mix_col(rk[127:96]), aes_inv_mix_col(rk[95:64]),
            aes_inv_mix_col(rk[63:32]),  aes_inv_mix_col(rk[31:0])};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (SubBytes on one byte).
// Ports: i_byte - input byte; o_byte_c - substituted byte (combinational).
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte_c
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_byte_c = SBOX[i_byte];

endmodule

// File: rtl/aes256_dec_key_sched.sv
// AES-256 decryption key scheduler: expands a 256-bit key into 15 round keys,
// one per cycle, and serves them by index through a registered read port.
// Ports: clk/rst_n (async active-low); key_i/key_valid_i/key_ready_o key offer
// handshake; busy_o high during expansion; keys_valid_o high once all keys
// are stored; rd_round_i selects a key, returned on rd_key_o one cycle later.
// Optional macro AES_EQ_INV_CIPHER_EN: store rk[1..13] after InvMixColumns
// for the equivalent inverse cipher.
module aes256_dec_key_sched
  import aes_pkg::*;
#(
  parameter int unsigned NR   = AES256_NR,
  parameter int unsigned RK_W = AES_RK_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2*RK_W-1:0] key_i,
  input  logic            key_valid_i,
  output logic            key_ready_o,
  output logic            busy_o,
  output logic            keys_valid_o,
  input  logic [3:0]      rd_round_i,
  output logic [RK_W-1:0] rd_key_o
);

  localparam int unsigned IDX_W = 4;

  key_sched_state_e  r_state;
  logic [IDX_W-1:0]  r_ctr;
  logic              r_key_ready;
  logic              r_busy;
  logic              r_keys_valid;
  logic [RK_W-1:0]   r_rd_key;
  aes_rk_t           r_rk [AES256_NUM_RK];

  logic      w_accept;
  aes_rk_t   w_prev2;
  aes_word_t w_last;
  aes_word_t w_sub_in;
  aes_word_t w_sub_out;
  aes_word_t w_t;
  aes_word_t w_k0, w_k1, w_k2, w_k3;
  aes_rk_t   w_new_rk;
  aes_rk_t   w_store_new;
  aes_rk_t   w_store_k1;
  logic [2:0] w_rcon_idx;
  logic [7:0] w_rcon;

  assign w_accept = key_valid_i & r_key_ready;

  // Recurrence sources: the raw rk[ctr-2] and last word of rk[ctr-1]
`ifdef AES_EQ_INV_CIPHER_EN
  aes_rk_t r_shadow2;
  aes_rk_t r_shadow1;
  assign w_prev2 = r_shadow2;
  assign w_last  = r_shadow1[31:0];
`else
  logic [IDX_W-1:0] w_idx_m2;
  logic [IDX_W-1:0] w_idx_m1;
  assign w_idx_m2 = IDX_W'(r_ctr - IDX_W'(2));
  assign w_idx_m1 = IDX_W'(r_ctr - IDX_W'(1));
  assign w_prev2  = r_rk[w_idx_m2];
  assign w_last   = r_rk[w_idx_m1][31:0];
`endif

  // Even keys use RotWord + RCON, odd keys use plain SubWord
  assign w_sub_in = r_ctr[0] ? w_last : {w_last[23:0], w_last[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte   (w_sub_in[8*g +: 8]),
      .o_byte_c (w_sub_out[8*g +: 8])
    );
  end

  // ctr/2-1 indexes RCON; out-of-range only outside EXPAND, so zero it
  assign w_rcon_idx = 3'(r_ctr[3:1] - 3'd1);
  assign w_rcon     = (w_rcon_idx < 3'd7) ? AES_RCON[w_rcon_idx] : 8'h00;
  assign w_t        = r_ctr[0] ? w_sub_out : (w_sub_out ^ {w_rcon, 24'h000000});

  assign w_k0     = w_prev2[127:96] ^ w_t;
  assign w_k1     = w_prev2[95:64]  ^ w_k0;
  assign w_k2     = w_prev2[63:32]  ^ w_k1;
  assign w_k3     = w_prev2[31:0]   ^ w_k2;
  assign w_new_rk = {w_k0, w_k1, w_k2, w_k3};

  // Stored form of each key; first and last round keys stay unmodified
`ifdef AES_EQ_INV_CIPHER_EN
  assign w_store_new = (r_ctr == IDX_W'(NR)) ? w_new_rk : aes_inv_mix_rk(w_new_rk);
  assign w_store_k1  = aes_inv_mix_rk(key_i[127:0]);
`else
  assign w_store_new = w_new_rk;
  assign w_store_k1  = key_i[127:0];
`endif

  // Round-key store: not reset, reads are masked until keys_valid
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rk[0] <= key_i[255:128];
      r_rk[1] <= w_store_k1;
    end else if (r_state == KS_EXPAND) begin
      r_rk[r_ctr] <= w_store_new;
    end
  end

`ifdef AES_EQ_INV_CIPHER_EN
  // Raw copies of the two most recent keys feed the recurrence
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shadow2 <= key_i[255:128];
      r_shadow1 <= key_i[127:0];
    end else if (r_state == KS_EXPAND) begin
      r_shadow2 <= r_shadow1;
      r_shadow1 <= w_new_rk;
    end
  end
`endif

  // Control FSM with registered handshake/status outputs and read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= KS_IDLE;
      r_ctr        <= '0;
      r_key_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_keys_valid <= 1'b0;
      r_rd_key     <= '0;
    end else begin
      r_rd_key <= (r_keys_valid && (rd_round_i <= IDX_W'(NR))) ? r_rk[rd_round_i] : '0;
      case (r_state)
        KS_IDLE, KS_DONE: begin
          if (w_accept) begin
            r_state      <= KS_EXPAND;
            r_ctr        <= IDX_W'(2);
            r_key_ready  <= 1'b0;
            r_busy       <= 1'b1;
            r_keys_valid <= 1'b0;
          end
        end
        KS_EXPAND: begin
          r_ctr <= IDX_W'(r_ctr + IDX_W'(1));
          if (r_ctr == IDX_W'(NR)) begin
            r_state      <= KS_DONE;
            r_key_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_keys_valid <= 1'b1;
          end
        end
        default: r_state <= KS_IDLE;
      endcase
    end
  end

  assign key_ready_o  = r_key_ready;
  assign busy_o       = r_busy;
  assign keys_valid_o = r_keys_valid;
  assign rd_key_o     = r_rd_key;

endmodule

// File: tb/tb_aes256_dec_key_sched.sv
// Self-checking bench for aes256_dec_key_sched: FIPS-197 key expansion model
// (algebraic S-box), per-cycle output comparison and directed vectors.
// Honours AES_EQ_INV_CIPHER_EN when defined for the design.
`timescale 1ns/1ps
module tb_aes256_dec_key_sched;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] key_i = '0;
  logic         key_valid_i = 1'b0;
  logic [3:0]   rd_round_i = '0;
  logic         key_ready_o;
  logic         busy_o;
  logic         keys_valid_o;
  logic [127:0] rd_key_o;

  always #5 clk = ~clk;

  aes256_dec_key_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_i        (key_i),
    .key_valid_i  (key_valid_i),
    .key_ready_o  (key_ready_o),
    .busy_o       (busy_o),
    .keys_valid_o (keys_valid_o),
    .rd_round_i   (rd_round_i),
    .rd_key_o     (rd_key_o)
  );

  localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] A3_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] A3_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [127:0] C3_RK0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C3_RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse then affine map
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [7:0] a [4];
    logic [31:0] res = '0;
    for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
    for (int r = 0; r < 4; r++) begin
      logic [7:0] acc = 8'h00;
      for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - r + 4) % 4], a[k]);
      res[31-8*r -: 8] = acc;
    end
    return res;
  endfunction

  function automatic logic [127:0] inv_mix_rk(input logic [127:0] rk);
    return {inv_mix_col(rk[127:96]), inv_mix_col(rk[95:64]), inv_mix_col(rk[63:32]), inv_mix_col(rk[31:0])};
  endfunction

  logic [127:0] m_rk [15];

  // Textbook word-wise expansion of 60 words w[0..59]
  function automatic void model_expand(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int r = 0; r < 15; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // ---------------- cycle-level behavioural model ----------------
  logic         m_ready = 1'b1;
  logic         m_busy  = 1'b0;
  logic         m_valid = 1'b0;
  logic [127:0] m_rd    = '0;
  logic [127:0] m_nxt;
  int           m_left  = 0;
  logic [127:0] m_cur [15];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready = 1'b1; m_busy = 1'b0; m_valid = 1'b0; m_rd = '0; m_left = 0;
    end else begin
      m_nxt = (m_valid && rd_round_i <= 4'd14) ? m_cur[rd_round_i] : '0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin m_busy = 1'b0; m_ready = 1'b1; m_valid = 1'b1; end
      end else if (key_valid_i) begin
        model_expand(key_i);
        for (int r = 0; r < 15; r++) begin
`ifdef AES_EQ_INV_CIPHER_EN
          m_cur[r] = (r >= 1 && r <= 13) ? inv_mix_rk(m_rk[r]) : m_rk[r];
`else
          m_cur[r] = m_rk[r];
`endif
        end
        m_busy = 1'b1; m_ready = 1'b0; m_valid = 1'b0; m_left = 13;
      end
      m_rd = m_nxt;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_key_ready", 128'(key_ready_o), 128'(m_ready));
      check("cyc_busy", 128'(busy_o), 128'(m_busy));
      check("cyc_keys_valid", 128'(keys_valid_o), 128'(m_valid));
      check("cyc_rd_key", rd_key_o, m_rd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_key(input logic [255:0] k);
    key_i = k;
    key_valid_i = 1'b1;
    tick();
    key_valid_i = 1'b0;
  endtask

  // Called just after the accept edge; checks latency and busy duration
  task automatic wait_keys(input string name);
    int n = 0;
    int b = 0;
    check({name, "_drop_valid"}, 128'(keys_valid_o), 128'(0));
    b += int'(busy_o);
    while (!keys_valid_o && n < 40) begin
      tick();
      n++;
      b += int'(busy_o);
    end
    check({name, "_latency"}, 128'(n), 128'(13));
    check({name, "_busy_cycles"}, 128'(b), 128'(13));
  endtask

  task automatic read_rk(input logic [3:0] idx, output logic [127:0] data);
    rd_round_i = idx;
    tick();
    data = rd_key_o;
  endtask

  task automatic sweep(input string name);
    for (int i = 14; i >= 0; i--) begin
      rd_round_i = 4'(i);
      tick();
      check(name, rd_key_o, m_cur[i]);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_key_ready"}, 128'(key_ready_o), 128'(1));
    check({name, "_busy"}, 128'(busy_o), 128'(0));
    check({name, "_keys_valid"}, 128'(keys_valid_o), 128'(0));
    check({name, "_rd_key"}, rd_key_o, 128'(0));
  endtask

  initial begin
    logic [127:0] d;
    #12;
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Pin the reference model to published values
    model_expand(KEY_A3);
    check("model_a3_rk2", m_rk[2], A3_RK2);
    check("model_a3_rk14", m_rk[14], A3_RK14);
    model_expand(KEY_C3);
    check("model_c3_rk0", m_rk[0], C3_RK0);
    check("model_c3_rk14", m_rk[14], C3_RK14);
    check("model_invmix", 128'(inv_mix_col(32'h8e4da1bc)), 128'(32'hdb135345));

    // A.3 key, reads during expansion masked, stray key offer ignored
    tick();
    accept_key(KEY_A3);
    rd_round_i = 4'd14;
    tick();
    check("read_during_expand", rd_key_o, 128'(0));
    key_i = KEY_C3;
    key_valid_i = 1'b1;
    tick();
    key_valid_i = 1'b0;
    check("read_during_expand2", rd_key_o, 128'(0));
    check("ready_low_in_expand", 128'(key_ready_o), 128'(0));
    repeat (9) tick();
    check("still_busy", 128'(busy_o), 128'(1));
    while (!keys_valid_o) tick();
    read_rk(4'd14, d);
    check("a3_rk14", d, A3_RK14);
`ifndef AES_EQ_INV_CIPHER_EN
    read_rk(4'd2, d);
    check("a3_rk2", d, A3_RK2);
`endif
    read_rk(4'd15, d);
    check("oob_index", d, 128'(0));

    // Rekey in DONE: C.3 then A.3 back to back
    accept_key(KEY_C3);
    wait_keys("c3");
    read_rk(4'd14, d);
    check("c3_rk14", d, C3_RK14);
    read_rk(4'd0, d);
    check("c3_rk0", d, C3_RK0);
    sweep("c3_sweep");
    accept_key(KEY_A3);
    wait_keys("rekey_a3");
    read_rk(4'd14, d);
    check("rekey_a3_rk14", d, A3_RK14);
    sweep("rekey_a3_sweep");

    // Reset at E6 of an expansion, then a fresh full expansion
    accept_key(KEY_C3);
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_reset_outputs("after_abort");
    accept_key(KEY_A3);
    wait_keys("post_abort");
    read_rk(4'd14, d);
    check("post_abort_rk14", d, A3_RK14);
    read_rk(4'd0, d);
    check("post_abort_rk0", d, KEY_A3[255:128]);
    sweep("post_abort_sweep");

    tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
